// File: rtl/rtrt_pkg.sv
// Shared types and constants for the ray/sphere dispatcher and its engine link.
// Pure declarations: no logic, no latency, no backpressure.
package rtrt_pkg;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } vec3_t;

    typedef struct packed {
        logic [15:0] cx;
        logic [15:0] cy;
        logic [15:0] cz;
        logic [15:0] r;
    } sphere_t;

    typedef enum logic [2:0] {DRAIN, IDLE, ISSUE, WAIT, DONE} rsd_state_t;

    localparam int RSD_DRAIN_CYC = 4;
    localparam int IX_LATENCY    = 4;

endpackage

// File: rtl/ray_sphere_dispatcher_if.sv
// Dispatcher-to-engine query link: ENABLE starts a query, READY/COLLIDE return the result.
// Engine clears READY on the ENABLE edge; request fields hold until READY or timeout.
interface ray_sphere_dispatcher_if;
    import rtrt_pkg::*;

    logic       ENABLE;
    sphere_t    sphere;
    vec3_t      p0;
    vec3_t      p1;
    logic       BOUNDED;
    logic [3:0] THRESHOLD;
    logic       READY;
    logic       COLLIDE;

    modport master (output ENABLE, sphere, p0, p1, BOUNDED, THRESHOLD,
                    input  READY, COLLIDE);
    modport slave  (input  ENABLE, sphere, p0, p1, BOUNDED, THRESHOLD,
                    output READY, COLLIDE);
endinterface

// File: rtl/sphere_table.sv
// Sphere register file: one synchronous write port, one asynchronous read port.
// Write lands on the next edge; entries are never reset.
module sphere_table
    import rtrt_pkg::*;
#(
    parameter int MAX_SPHERES = 16,
    parameter int IDX_W       = $clog2(MAX_SPHERES)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  sphere_t          wr_dat,
    input  logic [IDX_W-1:0] rd_addr,
    output sphere_t          rd_dat
);

    sphere_t mem [MAX_SPHERES];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_dat;
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/ray_sphere_dispatcher.sv
// Walks the sphere table for one accepted ray, one engine query per sphere; RSD_EARLY_EXIT_EN stops at first hit.
// 5 cycles per sphere (+1 for done); ray_ready only in IDLE, each query aborts after TIMEOUT_CYC WAIT cycles.
module ray_sphere_dispatcher
    import rtrt_pkg::*;
#(
    parameter int MAX_SPHERES = 16,
    parameter int IDX_W       = $clog2(MAX_SPHERES),
    parameter int TIMEOUT_CYC = 32
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_addr,
    input  sphere_t                wr_sphere,
    input  logic [IDX_W:0]         num_spheres,
    input  logic                   ray_valid,
    output logic                   ray_ready,
    input  vec3_t                  ray_p0,
    input  vec3_t                  ray_p1,
    input  logic                   ray_BOUNDED,
    input  logic [3:0]             ray_THRESHOLD,
    ray_sphere_dispatcher_if.master ix,
    output logic                   done,
    output logic                   hit,
    output logic [IDX_W-1:0]       hit_idx,
    output logic [MAX_SPHERES-1:0] hit_mask,
    output logic                   err_timeout
);

    localparam int DW = $clog2(RSD_DRAIN_CYC);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [DW-1:0]    DRAIN_LAST = DW'(RSD_DRAIN_CYC - 1);
    localparam logic [TW-1:0]    T_LAST     = TW'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W:0]   N_MAX      = (IDX_W+1)'(MAX_SPHERES);

    rsd_state_t       state, state_nxt;
    logic [DW-1:0]    drain_cnt;
    logic [TW-1:0]    tcnt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W:0]   n_lat, n_clamp, idx_inc;
    vec3_t            p0_q, p1_q;
    logic             bounded_q;
    logic [3:0]       thr_q;
    sphere_t          rd_sphere;
    logic             accept, resp, tmo;

    sphere_table #(.MAX_SPHERES(MAX_SPHERES), .IDX_W(IDX_W)) u_table (
        .clk     (CLK),
        .wr_en   (wr_en && state == IDLE),
        .wr_addr (wr_addr),
        .wr_dat  (wr_sphere),
        .rd_addr (idx),
        .rd_dat  (rd_sphere)
    );

    assign n_clamp = (num_spheres > N_MAX) ? N_MAX : num_spheres;
    assign idx_inc = {1'b0, idx} + (IDX_W+1)'(1);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        resp      = 1'b0;
        tmo       = 1'b0;
        case (state)
            DRAIN: if (drain_cnt == DRAIN_LAST) state_nxt = IDLE;
            IDLE: begin
                if (ray_valid) begin
                    accept    = 1'b1;
                    state_nxt = (n_clamp == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                // READY outranks a timeout expiring in the same cycle
                resp = ix.READY;
                tmo  = !ix.READY && (tcnt == T_LAST);
                if (resp || tmo) state_nxt = (idx_inc >= n_lat) ? DONE : ISSUE;
`ifdef RSD_EARLY_EXIT_EN
                if (resp && ix.COLLIDE) state_nxt = DONE;
`endif
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = DRAIN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= DRAIN;
            drain_cnt   <= '0;
            tcnt        <= '0;
            idx         <= '0;
            n_lat       <= '0;
            p0_q        <= '0;
            p1_q        <= '0;
            bounded_q   <= 1'b0;
            thr_q       <= '0;
            hit         <= 1'b0;
            hit_idx     <= '0;
            hit_mask    <= '0;
            err_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == DRAIN) drain_cnt <= drain_cnt + DW'(1);
            if (state == ISSUE)     tcnt <= '0;
            else if (state == WAIT) tcnt <= tcnt + TW'(1);
            if (accept) begin
                p0_q        <= ray_p0;
                p1_q        <= ray_p1;
                bounded_q   <= ray_BOUNDED;
                thr_q       <= ray_THRESHOLD;
                n_lat       <= n_clamp;
                idx         <= '0;
                hit         <= 1'b0;
                hit_idx     <= '0;
                hit_mask    <= '0;
                err_timeout <= 1'b0;
            end
            if (resp || tmo) begin
                hit_mask[idx] <= resp && ix.COLLIDE;
                if (resp && ix.COLLIDE && !hit) begin
                    hit     <= 1'b1;
                    hit_idx <= idx;
                end
                if (tmo) err_timeout <= 1'b1;
                idx <= idx + IDX_W'(1);
            end
        end
    end

    assign ray_ready    = (state == IDLE);
    assign done         = (state == DONE);
    assign ix.ENABLE    = (state == ISSUE);
    assign ix.sphere    = (state == ISSUE || state == WAIT) ? rd_sphere : '0;
    assign ix.p0        = p0_q;
    assign ix.p1        = p1_q;
    assign ix.BOUNDED   = bounded_q;
    assign ix.THRESHOLD = thr_q;

endmodule

// File: tb/tb_ray_sphere_dispatcher.sv
// Directed bench for ray_sphere_dispatcher with a behavioural 4-edge engine stand-in.
module tb_ray_sphere_dispatcher;
    import rtrt_pkg::*;

`ifdef RSD_EARLY_EXIT_EN
    localparam int        LAT_MULTI  = 11;
    localparam int        LAT_CLAMP  = 11;
    localparam bit [15:0] MASK_MULTI = 16'h0002;
`else
    localparam int        LAT_MULTI  = 16;
    localparam int        LAT_CLAMP  = 81;
    localparam bit [15:0] MASK_MULTI = 16'h0006;
`endif

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        wr_en, ray_valid, ray_ready, ray_BOUNDED;
    logic [3:0]  wr_addr, ray_THRESHOLD, hit_idx;
    sphere_t     wr_sphere;
    logic [4:0]  num_spheres;
    vec3_t       ray_p0, ray_p1;
    logic        done, hit, err_timeout;
    logic [15:0] hit_mask;

    int n_chk = 0;
    int n_fail = 0;
    int lat;
    logic saw_done;

    always #5 CLK = ~CLK;

    ray_sphere_dispatcher_if ix();

    ray_sphere_dispatcher dut (
        .CLK(CLK), .RESET(RESET), .wr_en(wr_en), .wr_addr(wr_addr), .wr_sphere(wr_sphere),
        .num_spheres(num_spheres), .ray_valid(ray_valid), .ray_ready(ray_ready),
        .ray_p0(ray_p0), .ray_p1(ray_p1), .ray_BOUNDED(ray_BOUNDED), .ray_THRESHOLD(ray_THRESHOLD),
        .ix(ix), .done(done), .hit(hit), .hit_idx(hit_idx), .hit_mask(hit_mask),
        .err_timeout(err_timeout)
    );

    // Engine stand-in: infinite-line discriminant test; the directed spheres either straddle the segment or miss entirely.
    function automatic bit line_hits(sphere_t s, vec3_t a, vec3_t b);
        longint ax, ay, az, dx, dy, dz, fx, fy, fz, rr, qa, qb, qc;
        ax = longint'($signed(a.x)); ay = longint'($signed(a.y)); az = longint'($signed(a.z));
        dx = longint'($signed(b.x)) - ax;
        dy = longint'($signed(b.y)) - ay;
        dz = longint'($signed(b.z)) - az;
        fx = ax - longint'($signed(s.cx));
        fy = ay - longint'($signed(s.cy));
        fz = az - longint'($signed(s.cz));
        rr = longint'($signed(s.r));
        qa = dx*dx + dy*dy + dz*dz;
        qb = 2 * (fx*dx + fy*dy + fz*dz);
        qc = fx*fx + fy*fy + fz*fz - rr*rr;
        return (qb*qb - 4*qa*qc) >= 0;
    endfunction

    logic eng_rdy = 1'b0, eng_col = 1'b0, eng_busy = 1'b0, eng_hit = 1'b0, eng_mute = 1'b0;
    int   eng_cnt = 0;
    assign ix.READY   = eng_rdy;
    assign ix.COLLIDE = eng_col;

    always @(posedge CLK) begin
        if (ix.ENABLE) begin
            eng_rdy  <= 1'b0;
            eng_busy <= 1'b1;
            eng_cnt  <= IX_LATENCY - 1;
            eng_hit  <= line_hits(ix.sphere, ix.p0, ix.p1);
        end else if (eng_busy) begin
            if (eng_cnt == 1) begin
                eng_busy <= 1'b0;
                eng_rdy  <= !eng_mute;
                eng_col  <= eng_hit;
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic sphere_t sph(int cx, int cy, int cz, int r);
        return {16'(cx), 16'(cy), 16'(cz), 16'(r)};
    endfunction

    task automatic wr(input int a, input sphere_t s);
        @(negedge CLK);
        wr_en = 1'b1; wr_addr = 4'(a); wr_sphere = s;
        @(negedge CLK);
        wr_en = 1'b0;
    endtask

    task automatic start_ray(input int n);
        int g = 0;
        while (!ray_ready && g < 50) begin
            @(negedge CLK);
            g++;
        end
        check("ready_before_accept", ray_ready, 1);
        num_spheres = 5'(n);
        ray_valid   = 1'b1;
        @(posedge CLK);
        #1 ray_valid = 1'b0;
    endtask

    // Returns the cycle (counted from the accept edge) in which done is seen, -1 if the bound expires.
    task automatic wait_done(input int first, input int limit, input int wr_at, output int l);
        l = -1;
        for (int c = first; c <= limit; c++) begin
            @(negedge CLK);
            wr_en = (c == wr_at);
            if (c == wr_at) begin
                wr_addr   = 4'd0;
                wr_sphere = sph(50, 50, 50, 2);
            end
            if (done) begin
                l = c;
                break;
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic check_drain();
        for (int i = 1; i <= 3; i++) begin
            @(negedge CLK);
            check("drain_ready_low", ray_ready, 0);
        end
        @(negedge CLK);
        check("drain_ready_up", ray_ready, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        wr_en = 1'b0; wr_addr = '0; wr_sphere = '0; num_spheres = '0; ray_valid = 1'b0;
        ray_p0 = {16'hFFF6, 16'h0000, 16'h0000};
        ray_p1 = {16'h000A, 16'h0000, 16'h0000};
        ray_BOUNDED = 1'b1; ray_THRESHOLD = 4'h5;

        repeat (2) @(negedge CLK);
        check("rst_ray_ready", ray_ready, 0);
        check("rst_enable", ix.ENABLE, 0);
        check("rst_done", done, 0);
        check("rst_hit", hit, 0);
        check("rst_mask", hit_mask, 0);
        check("rst_err", err_timeout, 0);
        RESET = 1'b0;
        check_drain();

        // single hit, with request fields checked during ISSUE
        wr(0, sph(0, 0, 0, 5));
        start_ray(1);
        @(negedge CLK);
        check("issue_enable", ix.ENABLE, 1);
        check("issue_sphere", ix.sphere, sph(0, 0, 0, 5));
        check("issue_p1", ix.p1, {16'h000A, 16'h0000, 16'h0000});
        check("issue_thr", ix.THRESHOLD, 4'h5);
        check("issue_bounded", ix.BOUNDED, 1);
        wait_done(2, 100, 0, lat);
        check("single_lat", 64'(lat), 6);
        check("single_hit", hit, 1);
        check("single_idx", hit_idx, 0);
        check("single_mask", hit_mask, 16'h0001);
        check("single_err", err_timeout, 0);
        @(negedge CLK);
        check("done_one_cycle", done, 0);
        check("hit_held", hit, 1);

        // write during WAIT must be dropped
        start_ray(1);
        wait_done(1, 100, 3, lat);
        check("gate_lat", 64'(lat), 6);
        start_ray(1);
        wait_done(1, 100, 0, lat);
        check("gate_hit", hit, 1);
        check("gate_mask", hit_mask, 16'h0001);

        // multi-sphere table
        wr(0, sph(50, 50, 50, 2));
        wr(1, sph(0, 0, 0, 5));
        wr(2, sph(0, 0, 0, 3));
        for (int i = 3; i < 16; i++) wr(i, sph(100, 100, 100, 1));
        start_ray(3);
        wait_done(1, 200, 0, lat);
        check("multi_lat", 64'(lat), 64'(LAT_MULTI));
        check("multi_mask", hit_mask, MASK_MULTI);
        check("multi_idx", hit_idx, 1);
        check("multi_hit", hit, 1);

        // n = 0
        start_ray(0);
        wait_done(1, 50, 0, lat);
        check("zero_lat", 64'(lat), 1);
        check("zero_hit", hit, 0);
        check("zero_mask", hit_mask, 0);

        // n clamped to table depth
        start_ray(20);
        wait_done(1, 300, 0, lat);
        check("clamp_lat", 64'(lat), 64'(LAT_CLAMP));
        check("clamp_mask", hit_mask, MASK_MULTI);

        // engine never answers
        eng_mute = 1'b1;
        start_ray(2);
        wait_done(1, 300, 0, lat);
        check("tmo_lat", 64'(lat), 67);
        check("tmo_err", err_timeout, 1);
        check("tmo_hit", hit, 0);
        check("tmo_mask", hit_mask, 0);
        eng_mute = 1'b0;

        // reset while waiting on sphere 1 of 3
        start_ray(3);
        saw_done = 1'b0;
        repeat (7) begin
            @(negedge CLK);
            saw_done = saw_done | done;
        end
        RESET = 1'b1;
        repeat (2) begin
            @(negedge CLK);
            saw_done = saw_done | done;
        end
        check("rst_mid_ready", ray_ready, 0);
        check("rst_mid_err", err_timeout, 0);
        RESET = 1'b0;
        check_drain();
        check("rst_mid_no_done", saw_done, 0);
        start_ray(3);
        wait_done(1, 200, 0, lat);
        check("post_rst_lat", 64'(lat), 64'(LAT_MULTI));
        check("post_rst_mask", hit_mask, MASK_MULTI);
        check("post_rst_idx", hit_idx, 1);

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ray_sphere_dispatcher.md
Name: ray_sphere_dispatcher

Overview:
- Initiator for the ray_sphere_intersection engine (ENABLE/READY/COLLIDE handshake).
- Accepts one ray (p0, p1, BOUNDED, THRESHOLD) through a valid/ready handshake.
- Walks a local sphere table, issues one query per sphere, and collects COLLIDE results.
- Reports a per-sphere hit mask and the lowest-index hit.

Parameters:
- MAX_SPHERES, 16, table depth.
- IDX_W, $clog2(MAX_SPHERES), index width.
- TIMEOUT_CYC, 32, maximum WAIT cycles per query before abort.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- wr_en  in  1  sphere table write strobe.
- wr_addr  in  IDX_W  table write address.
- wr_sphere  in  16x4  {cx, cy, cz, r}.
- num_spheres  in  IDX_W+1  number of active entries.
- ray_valid  in  1  ray request.
- ray_ready  out  1  dispatcher can accept a ray.
- ray_p0, ray_p1  in  16x3  ray endpoints.
- ray_BOUNDED  in  1  passed through to the engine.
- ray_THRESHOLD  in  4  passed through to the engine.
- ix_ENABLE  out  1  engine start.
- ix_sphere  out  16x4  sphere to engine.
- ix_p0, ix_p1  out  16x3  ray to engine.
- ix_BOUNDED  out  1  to engine.
- ix_THRESHOLD  out  4  to engine.
- ix_READY  in  1  engine done.
- ix_COLLIDE  in  1  engine result.
- done  out  1  one-cycle result strobe.
- hit  out  1  any sphere collided.
- hit_idx  out  IDX_W  lowest colliding index.
- hit_mask  out  MAX_SPHERES  per-sphere collide bits.
- err_timeout  out  1  at least one query timed out.

Behaviour:
- Interface: one clock CLK; RESET synchronous, active-high. On RESET all outputs go to 0, including ray_ready, ix_ENABLE and done. The state machine enters DRAIN.
- States: DRAIN, IDLE, ISSUE, WAIT, DONE.
- DRAIN:
  - Lasts 4 cycles after RESET deasserts, counted by an internal counter. ray_ready=0 and ix_ENABLE=0.
  - Purpose: the engine has no reset and must return to its idle state before the first query.
  - Then go to IDLE.
- IDLE:
  - ray_ready=1.
  - Table writes are accepted here only; wr_en in any other state is ignored.
  - On ray_valid&&ray_ready, latch the ray. Latch n = min(num_spheres, MAX_SPHERES). Clear hit, hit_mask, err_timeout; set idx=0.
  - If n=0, go to DONE; otherwise go to ISSUE.
- ISSUE:
  - ix_ENABLE=1 for exactly this one cycle.
  - ix_sphere=table[idx]; ix_p0, ix_p1, ix_BOUNDED, ix_THRESHOLD come from the latched ray. These outputs stay stable through WAIT.
  - Clear the timeout counter and go to WAIT.
- WAIT:
  - ix_ENABLE=0.
  - Because the engine clears READY on its accept edge, READY=1 seen in WAIT always belongs to the current query.
  - On ix_READY=1: hit_mask[idx] <= ix_COLLIDE. If ix_COLLIDE and hit==0, set hit=1 and hit_idx=idx. Then idx+1; go to ISSUE if idx+1<n, else DONE.
  - If the counter reaches TIMEOUT_CYC without READY: set err_timeout=1, mask bit=0, and advance as above.
- DONE: done=1 for one cycle; hit, hit_idx, hit_mask and err_timeout stay held until the next ray is accepted. Go to IDLE.
- Latency:
  - The engine returns READY 4 edges after accept, so each sphere takes 5 cycles (ISSUE + 4 WAIT).
  - done is high exactly 5n+1 cycles after the accept edge; for n=0 it is high the cycle after accept.
- Simultaneous events: if ix_READY and timeout expiry occur in the same cycle, READY wins.
- Reset mid-operation: results are abandoned and the block re-enters DRAIN; no done is produced.
- The table contents are undefined until written; entries are not cleared by reset.

Optional Feature:
- Macro: RSD_EARLY_EXIT_EN.
- Defined: WAIT goes to DONE on the first ix_COLLIDE=1. Bits above hit_idx stay 0, and latency is 5*(hit_idx+1)+1.
- Undefined: all n spheres are always queried, giving fixed 5n+1 latency.

Decomposition:
- Package rtrt_pkg:
  - vec3_t (16-bit x3) and sphere_t (16-bit x4) typedefs.
  - Enum rsd_state_t.
  - Constants RSD_DRAIN_CYC=4 and IX_LATENCY=4.
- Sub-module sphere_table: MAX_SPHERES x sphere_t register file with one write port and one asynchronous read port.

Test Plan:
- Single hit: table[0]={0,0,0,5}, n=1, ray (-10,0,0)->(10,0,0), real engine -> done at cycle 6; hit=1, hit_idx=0, hit_mask=0x0001.
- Multi-sphere: entries 0={50,50,50,2}, 1={0,0,0,5}, 2={0,0,0,3}, n=3, same ray -> done at cycle 16; hit_mask=0x0006, hit_idx=1. With RSD_EARLY_EXIT_EN -> done at cycle 11, hit_mask=0x0002.
- Zero/clamp: n=0 -> done at cycle 1, hit=0. n=20 -> 16 queries, done at cycle 81.
- Timeout: engine model that never raises READY, n=2 -> done at cycle 2*(1+32)+1=67; err_timeout=1, hit=0.
- Reset mid-WAIT: assert RESET during sphere 1 of 3 -> no done; ray_ready=0 for 4 cycles after release, then 1. The next ray completes correctly.
- Write gating: wr_en during WAIT to addr 0 -> table unchanged; verified by the next ray's result.
